// File: rtl/fpga_link_rx_if.sv
// rtl/fpga_link_rx_if.sv - link pins and output stream of the FPGA link receiver
// slave is the receiver; master is the sender plus downstream consumer.
interface fpga_link_rx_if #(
   parameter int DATA_W = 32
) ();
   logic [DATA_W-1:0] data_in;
   logic              req_in;
   logic              stb_in;
   logic              rdy_out;
   logic              ack_out;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;

   modport master (
      output data_in, req_in, stb_in, m_ready,
      input  rdy_out, ack_out, m_data, m_valid
   );

   modport slave (
      input  data_in, req_in, stb_in, m_ready,
      output rdy_out, ack_out, m_data, m_valid
   );
endinterface

// File: rtl/fpga_link_rx.sv
// rtl/fpga_link_rx.sv - receive side of the FPGA-to-FPGA parallel burst link
// Synchronises req/strobe, grants bursts only with room for a whole burst, buffers words in a FIFO.
module fpga_link_rx #(
   parameter int DATA_W      = 32,
   parameter int BURST_LEN   = 10,
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024,
   localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic           clk,
   input  logic           rst,
   fpga_link_rx_if.slave  link,
   output logic [LW-1:0]  level,
   output logic           burst_done,
   output logic           err_short,
   output logic           err_timeout
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(BURST_LEN + 1);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, RECEIVE, ACK, WAIT_LOW} state_t;

   state_t                   state;
   logic [SYNC_STAGES-1:0]   req_sync;
   logic [SYNC_STAGES-1:0]   stb_sync;
   logic                     stb_prev;
   logic                     req_s;
   logic                     stb_edge;
   logic [CW-1:0]            count;
   logic [CW-1:0]            count_next;
   logic [TW-1:0]            tcnt;
   logic [TW-1:0]            tcnt_next;
   logic [DATA_W-1:0]        mem [FIFO_DEPTH];
   logic [LW-1:0]            wptr;
   logic [LW-1:0]            rptr;
   logic                     full;
   logic                     wr_en;
   logic                     rd_en;

   assign req_s    = req_sync[SYNC_STAGES-1];
   assign stb_edge = stb_sync[SYNC_STAGES-1] ^ stb_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         req_sync <= '0;
         stb_sync <= '0;
         stb_prev <= 1'b0;
      end else begin
         req_sync <= {req_sync[SYNC_STAGES-2:0], link.req_in};
         stb_sync <= {stb_sync[SYNC_STAGES-2:0], link.stb_in};
         stb_prev <= stb_sync[SYNC_STAGES-1];
      end
   end

   // Pointer MSB distinguishes full from empty when the low bits match.
   assign level        = wptr - rptr;
   assign full         = (level == LW'(FIFO_DEPTH));
   assign link.m_valid = (level != '0);
   assign link.m_data  = mem[rptr[AW-1:0]];
   assign rd_en        = link.m_valid & link.m_ready;
   assign wr_en        = (state == RECEIVE) & stb_edge & ~full;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wptr[AW-1:0]] <= link.data_in;
            wptr              <= wptr + 1'b1;
         end
         if (rd_en) rptr <= rptr + 1'b1;
      end
   end

   always_comb begin
      count_next = count;
      if (stb_edge && count != CW'(BURST_LEN)) count_next = count + 1'b1;
      tcnt_next = (tcnt == TW'(TIMEOUT)) ? tcnt : tcnt + 1'b1;
   end

   // Completion is tested on the post-strobe count so a last word arriving with req falling wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         link.rdy_out <= 1'b0;
         link.ack_out <= 1'b0;
         count        <= '0;
         tcnt         <= '0;
         burst_done   <= 1'b0;
         err_short    <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         burst_done  <= 1'b0;
         err_short   <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (req_s && (LW'(FIFO_DEPTH) - level) >= LW'(BURST_LEN)) begin
                  state        <= RECEIVE;
                  link.rdy_out <= 1'b1;
                  count        <= '0;
                  tcnt         <= '0;
               end
            end
            RECEIVE: begin
               count <= count_next;
               tcnt  <= stb_edge ? '0 : tcnt_next;
               if (count_next == CW'(BURST_LEN)) begin
                  state        <= ACK;
                  link.rdy_out <= 1'b0;
                  link.ack_out <= 1'b1;
                  burst_done   <= 1'b1;
               end else if (!req_s) begin
                  state        <= IDLE;
                  link.rdy_out <= 1'b0;
                  err_short    <= 1'b1;
               end else if (TIMEOUT != 0 && !stb_edge && tcnt_next == TW'(TIMEOUT)) begin
                  state        <= WAIT_LOW;
                  link.rdy_out <= 1'b0;
                  err_timeout  <= 1'b1;
               end
            end
            ACK: begin
               if (!req_s) begin
                  state        <= IDLE;
                  link.ack_out <= 1'b0;
               end
            end
            WAIT_LOW: begin
               if (!req_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fpga_link_rx.sv
// tb/tb_fpga_link_rx.sv - directed-random bench for fpga_link_rx against a queue model
// Outputs are sampled on the falling edge; inputs change right after it.
module tb_fpga_link_rx;
   localparam int DW  = 32;
   localparam int BL  = 4;
   localparam int FD  = 8;
   localparam int SS  = 2;
   localparam int TMO = 16;
   localparam int LW  = $clog2(FD) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [LW-1:0] level;
   logic          burst_done, err_short, err_timeout;

   fpga_link_rx_if #(.DATA_W(DW)) link ();

   fpga_link_rx #(
      .DATA_W(DW), .BURST_LEN(BL), .FIFO_DEPTH(FD), .SYNC_STAGES(SS), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .link(link.slave), .level(level),
      .burst_done(burst_done), .err_short(err_short), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] model[$];
   int n_pass = 0;
   int n_total = 0;
   int n_done, n_short, n_tmo, ack_seen;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: score any read taking place at the coming edge, then sample at the falling edge.
   task automatic tick();
      if (!rst && link.m_valid && link.m_ready) begin
         if (model.size() == 0) chk("rd_extra", 64'(level), 64'd0);
         else chk("rd_data", 64'(link.m_data), 64'(model.pop_front()));
      end
      @(posedge clk);
      @(negedge clk);
      if (burst_done) n_done++;
      if (err_short) n_short++;
      if (err_timeout) n_tmo++;
      if (link.ack_out) ack_seen++;
   endtask

   task automatic clear_counts();
      n_done = 0; n_short = 0; n_tmo = 0; ack_seen = 0;
   endtask

   task automatic request(input string tag);
      int n = 0;
      link.req_in = 1'b1;
      while (!link.rdy_out && n < 30) begin tick(); n++; end
      chk(tag, 64'(n), 64'(SS + 1));
   endtask

   task automatic send_word(input logic [DW-1:0] d, input bit stored);
      link.data_in = d;
      link.stb_in  = ~link.stb_in;
      if (stored) model.push_back(d);
      repeat (SS + 3) tick();
   endtask

   task automatic release_req(input string tag, input int exp_n);
      int n = 0;
      link.req_in = 1'b0;
      while ((link.ack_out || link.rdy_out) && n < 30) begin tick(); n++; end
      chk(tag, 64'(n), 64'(exp_n));
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((model.size() != 0 || level != 0) && n < 300) begin
         link.m_ready = 1'($urandom_range(0, 1));
         tick(); n++;
      end
      link.m_ready = 1'b0;
      chk({tag, "_level"}, 64'(level), 64'd0);
      chk({tag, "_model"}, 64'(model.size()), 64'd0);
   endtask

   initial begin
      int n;
      link.data_in = '0; link.req_in = 1'b0; link.stb_in = 1'b0; link.m_ready = 1'b0;
      clear_counts();
      @(negedge clk);
      repeat (3) tick();
      chk("rst_rdy", 64'(link.rdy_out), 64'd0);
      chk("rst_ack", 64'(link.ack_out), 64'd0);
      chk("rst_valid", 64'(link.m_valid), 64'd0);
      chk("rst_data", 64'(link.m_data), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_pulses", 64'({burst_done, err_short, err_timeout}), 64'd0);
      rst = 1'b0;
      tick();

      // Nominal burst with the consumer always ready.
      clear_counts();
      link.m_ready = 1'b1;
      request("nom_grant_lat");
      for (int i = 0; i < BL; i++) send_word(DW'(32'hA0 + i), 1'b1);
      chk("nom_ack", 64'(link.ack_out), 64'd1);
      chk("nom_done_once", 64'(n_done), 64'd1);
      release_req("nom_ack_drop_lat", SS + 1);
      chk("nom_level", 64'(level), 64'd0);
      chk("nom_model", 64'(model.size()), 64'd0);
      link.m_ready = 1'b0;

      // Back-pressure: two bursts fill the FIFO, a third waits for room.
      for (int b = 0; b < 2; b++) begin
         request("bp_grant_lat");
         for (int i = 0; i < BL; i++) send_word($urandom, 1'b1);
         release_req("bp_release", SS + 1);
      end
      chk("bp_level_full", 64'(level), 64'(FD));
      link.req_in = 1'b1;
      repeat (10) tick();
      chk("bp_no_grant", 64'(link.rdy_out), 64'd0);
      link.m_ready = 1'b1;
      repeat (BL) tick();
      link.m_ready = 1'b0;
      n = 0;
      while (!link.rdy_out && n < 30) begin tick(); n++; end
      chk("bp_late_grant", 64'(n <= SS + 1), 64'd1);
      for (int i = 0; i < BL; i++) send_word($urandom, 1'b1);
      release_req("bp_release3", SS + 1);
      chk("bp_level_vs_model", 64'(level), 64'(model.size()));
      drain("bp_drain");

      // Short burst: request dropped after two words.
      clear_counts();
      request("short_grant_lat");
      for (int i = 0; i < 2; i++) send_word($urandom, 1'b1);
      link.req_in = 1'b0;
      repeat (SS + 4) tick();
      chk("short_err_once", 64'(n_short), 64'd1);
      chk("short_no_done", 64'(n_done), 64'd0);
      chk("short_no_ack", 64'(ack_seen), 64'd0);
      chk("short_rdy_low", 64'(link.rdy_out), 64'd0);
      chk("short_level", 64'(level), 64'd2);
      request("short_next_grant");
      for (int i = 0; i < BL; i++) send_word($urandom, 1'b1);
      chk("short_next_done", 64'(n_done), 64'd1);
      release_req("short_next_release", SS + 1);
      drain("short_drain");

      // Timeout: one word then silence.
      clear_counts();
      request("tmo_grant_lat");
      link.data_in = $urandom;
      link.stb_in  = ~link.stb_in;
      model.push_back(link.data_in);
      n = 0;
      while (level != 1 && n < 20) begin tick(); n++; end
      chk("tmo_word_written", 64'(level), 64'd1);
      n = 0;
      while (!err_timeout && n < 60) begin tick(); n++; end
      chk("tmo_latency", 64'(n), 64'(TMO));
      chk("tmo_rdy_low", 64'(link.rdy_out), 64'd0);
      repeat (10) tick();
      chk("tmo_err_once", 64'(n_tmo), 64'd1);
      chk("tmo_holds_wait", 64'(link.rdy_out), 64'd0);
      link.req_in = 1'b0;
      repeat (SS + 2) tick();
      request("tmo_regrant");
      for (int i = 0; i < BL; i++) send_word($urandom, 1'b1);
      release_req("tmo_release", SS + 1);
      drain("tmo_drain");

      // Read and write in the same cycle at level 3, then stray strobes in IDLE.
      request("rw_grant_lat");
      for (int i = 0; i < BL - 1; i++) send_word($urandom, 1'b1);
      chk("rw_level3", 64'(level), 64'd3);
      link.data_in = $urandom;
      link.stb_in  = ~link.stb_in;
      model.push_back(link.data_in);
      repeat (SS) tick();
      link.m_ready = 1'b1;
      tick();
      link.m_ready = 1'b0;
      chk("rw_level_same", 64'(level), 64'd3);
      repeat (2) tick();
      release_req("rw_release", SS + 1);
      for (int i = 0; i < 3; i++) send_word($urandom, 1'b0);
      chk("stray_no_write", 64'(level), 64'd3);
      drain("rw_drain");

      // Reset in the middle of a burst.
      clear_counts();
      request("rst_grant_lat");
      for (int i = 0; i < 2; i++) send_word($urandom, 1'b1);
      rst = 1'b1;
      link.req_in = 1'b0;
      link.stb_in = 1'b0;
      repeat (2) tick();
      model.delete();
      chk("midrst_outputs", 64'({link.rdy_out, link.ack_out, link.m_valid, burst_done, err_short, err_timeout}), 64'd0);
      chk("midrst_level", 64'(level), 64'd0);
      chk("midrst_no_err", 64'(n_short), 64'd0);
      rst = 1'b0;
      tick();
      clear_counts();
      link.m_ready = 1'b1;
      request("post_rst_grant");
      for (int i = 0; i < BL; i++) send_word($urandom, 1'b1);
      chk("post_rst_done", 64'(n_done), 64'd1);
      release_req("post_rst_release", SS + 1);
      link.m_ready = 1'b0;
      drain("post_rst_drain");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
